// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM encoding, line levels and
// helpers that place the three majority-vote taps in the middle of a bit.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_CHK = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP_CHK  = 3'd4,
    DONE      = 3'd5
  } rx_state_t;

  // Line levels, identical to the ones the uart_tx end drives.
  localparam logic STOP_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;

  // First of the three consecutive sampling taps around mid-bit.
  function automatic int samp_first(input int prescale);
    return prescale / 2 - 1;
  endfunction

  // First edge at which the majority of all three taps is usable.
  function automatic int samp_valid(input int prescale);
    return prescale / 2 + 2;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter with a 3-tap mid-bit majority vote. Flags the end of
// each bit and the first edge at which the voted value is stable.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic rx_s,
  output logic bit_val,
  output logic sample_done,
  output logic bit_end
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] TAP0  = CW'(samp_first(PRESCALE));
  localparam logic [CW-1:0] VALID = CW'(samp_valid(PRESCALE));
  localparam logic [CW-1:0] LAST  = CW'(PRESCALE - 1);

  logic [CW-1:0] edge_cnt_reg;
  logic [2:0]    samp_reg;
  logic [2:0]    tap_hit;

  for (genvar gi = 0; gi < 3; gi++) begin : g_tap
    assign tap_hit[gi] = run && (edge_cnt_reg == TAP0 + CW'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_reg <= '0;
      samp_reg     <= '1;
    end else begin
      if (!run || edge_cnt_reg == LAST)
        edge_cnt_reg <= '0;
      else
        edge_cnt_reg <= edge_cnt_reg + 1'b1;
      for (int i = 0; i < 3; i++)
        if (tap_hit[i]) samp_reg[i] <= rx_s;
    end
  end

  assign bit_val     = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & samp_reg[2]) |
                       (samp_reg[1] & samp_reg[2]);
  assign sample_done = run && (edge_cnt_reg == VALID);
  assign bit_end     = run && (edge_cnt_reg == LAST);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, WIDTH data bits LSB first, optional parity, one stop.
// Delivers the word with a one-cycle DATA_VALID and flags parity/framing errors.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   PRESCALE = 8,
  parameter logic STOP     = STOP_LVL,
  parameter logic START    = START_LVL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR,
  output logic             Busy
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  rx_state_t        state_reg, state_next;
  logic             rx_meta_reg, rx_s_reg;
  logic [BW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] p_data_reg;
  logic             par_en_reg, par_typ_reg, par_bad_reg;
  logic             data_valid_reg, par_err_reg, stp_err_reg;
  logic             start_det, run, bit_val, sample_done, bit_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= RX_IN;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // The detection cycle itself is edge 0 of the start bit.
  assign start_det = (state_reg == IDLE) && (rx_s_reg == START);
  assign run       = start_det || (state_reg != IDLE && state_reg != DONE);

  uart_rx_sampler #(.PRESCALE(PRESCALE)) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .rx_s       (rx_s_reg),
    .bit_val    (bit_val),
    .sample_done(sample_done),
    .bit_end    (bit_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (start_det) state_next = START_CHK;
      START_CHK: if (bit_end) state_next = (bit_val == START) ? DATA : IDLE;
      DATA:      if (bit_end && bit_cnt_reg == LAST_BIT)
                   state_next = par_en_reg ? PARITY : STOP_CHK;
      PARITY:    if (bit_end) state_next = STOP_CHK;
      // Deciding mid stop bit leaves time to re-arm before a back-to-back start.
      STOP_CHK:  if (sample_done) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      p_data_reg     <= '0;
      par_en_reg     <= 1'b0;
      par_typ_reg    <= 1'b0;
      par_bad_reg    <= 1'b0;
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      par_err_reg    <= 1'b0;
      stp_err_reg    <= 1'b0;
      case (state_reg)
        IDLE: if (start_det) begin
          par_en_reg  <= PAR_EN;
          par_typ_reg <= PAR_TYP;
          par_bad_reg <= 1'b0;
          bit_cnt_reg <= '0;
        end
        DATA: if (bit_end) begin
          shift_reg[bit_cnt_reg] <= bit_val;
          bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + 1'b1;
        end
        PARITY: if (bit_end && (bit_val != (^shift_reg ^ par_typ_reg)))
          par_bad_reg <= 1'b1;
        // Strobes register here so they coincide with DONE and the new P_DATA.
        STOP_CHK: if (sample_done) begin
          par_err_reg <= par_bad_reg;
          stp_err_reg <= (bit_val != STOP);
          if (!par_bad_reg && bit_val == STOP) begin
            data_valid_reg <= 1'b1;
            p_data_reg     <= shift_reg;
          end
        end
        DONE: begin
          par_bad_reg <= 1'b0;
          bit_cnt_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign P_DATA     = p_data_reg;
  assign DATA_VALID = data_valid_reg;
  assign PAR_ERR    = par_err_reg;
  assign STP_ERR    = stp_err_reg;
  assign Busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at PRESCALE=8: clean, parity-error, framing-error,
// glitch, back-to-back and mid-frame-reset scenarios.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       Busy;

  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt, par_cnt, stp_cnt, busy_cnt;
  logic [7:0] data_q[$];

  uart_rx #(.WIDTH(8), .PRESCALE(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .Busy      (Busy)
  );

  always #5 clk = ~clk;

  // Strobe and busy-cycle tally, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (DATA_VALID) begin
        valid_cnt++;
        data_q.push_back(P_DATA);
      end
      if (PAR_ERR) par_cnt++;
      if (STP_ERR) stp_cnt++;
      if (Busy) busy_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    valid_cnt = 0;
    par_cnt   = 0;
    stp_cnt   = 0;
    busy_cnt  = 0;
    data_q.delete();
  endtask

  // Drives up to max_bits bits of a frame, PRESCALE clocks each, then idles high.
  task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                            input logic sb, input int max_bits);
    logic [10:0] f;
    int n;
    if (pe) begin
      f = {sb, pb, d, 1'b0};
      n = 11;
    end else begin
      f = {1'b1, sb, d, 1'b0};
      n = 10;
    end
    for (int i = 0; i < n && i < max_bits; i++) begin
      RX_IN = f[i];
      repeat (8) @(negedge clk);
    end
    RX_IN = 1'b1;
  endtask

  initial begin
    rst     = 1'b0;
    RX_IN   = 1'b1;
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    chk("rst_pdata", 32'(P_DATA), 32'h0);
    chk("rst_valid", 32'(DATA_VALID), 32'h0);
    chk("rst_parerr", 32'(PAR_ERR), 32'h0);
    chk("rst_stperr", 32'(STP_ERR), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Clean frame 0xA5, even parity bit 0.
    clr();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 11);
    repeat (16) @(negedge clk);
    chk("a5_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("a5_data_at_valid", (data_q.size() > 0) ? 32'(data_q[0]) : 32'hDEAD, 32'hA5);
    chk("a5_par_cnt", 32'(par_cnt), 32'd0);
    chk("a5_stp_cnt", 32'(stp_cnt), 32'd0);
    chk("a5_busy_cycles", 32'(busy_cnt), 32'd87);
    chk("a5_pdata", 32'(P_DATA), 32'hA5);

    // Same frame with a wrong parity bit.
    clr();
    send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 11);
    repeat (16) @(negedge clk);
    chk("bp_par_cnt", 32'(par_cnt), 32'd1);
    chk("bp_valid_cnt", 32'(valid_cnt), 32'd0);
    chk("bp_stp_cnt", 32'(stp_cnt), 32'd0);
    chk("bp_pdata_kept", 32'(P_DATA), 32'hA5);

    // No parity, frame 0x3C with a low stop bit.
    clr();
    PAR_EN = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 10);
    repeat (16) @(negedge clk);
    chk("fe_stp_cnt", 32'(stp_cnt), 32'd1);
    chk("fe_valid_cnt", 32'(valid_cnt), 32'd0);
    chk("fe_par_cnt", 32'(par_cnt), 32'd0);
    chk("fe_pdata_kept", 32'(P_DATA), 32'hA5);

    // Two-clock glitch on the line.
    clr();
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (20) @(negedge clk);
    chk("gl_valid_cnt", 32'(valid_cnt), 32'd0);
    chk("gl_par_cnt", 32'(par_cnt), 32'd0);
    chk("gl_stp_cnt", 32'(stp_cnt), 32'd0);
    chk("gl_busy_cycles", 32'(busy_cnt), 32'd7);
    chk("gl_busy_now", 32'(Busy), 32'h0);

    // Back-to-back 0x01 then 0xFE, odd parity (both parity bits 0).
    clr();
    PAR_EN  = 1'b1;
    PAR_TYP = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1, 11);
    send_frame(8'hFE, 1'b1, 1'b0, 1'b1, 11);
    repeat (16) @(negedge clk);
    chk("b2b_valid_cnt", 32'(valid_cnt), 32'd2);
    chk("b2b_first", (data_q.size() > 0) ? 32'(data_q[0]) : 32'hDEAD, 32'h01);
    chk("b2b_second", (data_q.size() > 1) ? 32'(data_q[1]) : 32'hDEAD, 32'hFE);
    chk("b2b_err_cnt", 32'(par_cnt + stp_cnt), 32'd0);

    // Reset in the middle of the data bits of 0x55, then a clean 0x66.
    clr();
    PAR_TYP = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0, 1'b1, 4);
    chk("mr_busy_before", 32'(Busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("mr_busy_in_rst", 32'(Busy), 32'h0);
    chk("mr_pdata_in_rst", 32'(P_DATA), 32'h0);
    chk("mr_valid_in_rst", 32'(DATA_VALID), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    clr();
    send_frame(8'h66, 1'b1, 1'b0, 1'b1, 11);
    repeat (16) @(negedge clk);
    chk("mr_valid_cnt", 32'(valid_cnt), 32'd1);
    chk("mr_data_at_valid", (data_q.size() > 0) ? 32'(data_q[0]) : 32'hDEAD, 32'h66);
    chk("mr_err_cnt", 32'(par_cnt + stp_cnt), 32'd0);
    chk("mr_pdata", 32'(P_DATA), 32'h66);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the far end of the team's uart_tx link.
- Oversamples a serial line and recovers one frame: start bit, WIDTH data bits LSB first, optional parity bit, one stop bit.
- Presents the recovered byte on P_DATA with a one-cycle DATA_VALID strobe.
- Flags parity and stop-bit (framing) errors.
- Sits between the external RX pin and the system register/FIFO logic in the same clock domain.

Parameters:
- WIDTH, 8, number of data bits per frame.
- PRESCALE, 8, oversampling clocks per bit. Legal values are 8, 16 and 32.
- STOP, 1, idle/stop line level.
- START, 0, start bit level.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- RX_IN  input  1  serial line; asynchronous to clk.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  WIDTH  last correctly received data word.
- DATA_VALID  output  1  one-cycle strobe: P_DATA was updated.
- PAR_ERR  output  1  one-cycle strobe: parity mismatch.
- STP_ERR  output  1  one-cycle strobe: stop bit sampled as 0.
- Busy  output  1  high from start-bit detection until the frame ends.

Behaviour:
- Reset values (rst low, asynchronous): P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, Busy=0, state=IDLE, counters=0, synchroniser flops=1.
- Synchroniser: RX_IN passes through a 2-flop synchroniser. All logic below uses the synchronised signal rx_s, which lags RX_IN by 2 clk.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within each bit.
  - bit_cnt counts data bits 0..WIDTH-1.
  - edge_cnt wraps to 0 after PRESCALE-1 and bit_cnt advances on that wrap.
- Bit sampling: rx_s is sampled at edge_cnt = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1. The bit value is the majority of the 3 samples, valid from edge_cnt = PRESCALE/2+2.
- IDLE:
  - Busy=0.
  - When rx_s=START, go to START_CHK with edge_cnt=0. That cycle counts as edge 0.
- START_CHK, at the end of the bit:
  - Majority=START: go to DATA.
  - Otherwise (glitch): go to IDLE with no strobes.
- DATA:
  - The majority value is shifted into an internal shift register at bit position bit_cnt (LSB first).
  - After bit WIDTH-1: go to PARITY if PAR_EN=1, else STOP_CHK.
- PARITY:
  - Expected parity = XOR of the shifted data, inverted when PAR_TYP=1.
  - A mismatch latches an internal par_bad flag.
  - Then go to STOP_CHK.
- STOP_CHK: at edge_cnt = PRESCALE/2+2, evaluate the stop bit and go to DONE.
- DONE (1 cycle):
  - par_bad=1: PAR_ERR=1.
  - Stop majority=0: STP_ERR=1. Both error strobes may assert together.
  - No errors: P_DATA <= shift register and DATA_VALID=1.
  - Any error: P_DATA is unchanged.
  - Go to IDLE; clear par_bad and counters.
- Back-to-back frames: DONE occurs in the second half of the stop bit, so IDLE is reached before the next start edge at full baud rate.
- Busy: high in every state except IDLE.
- Configuration inputs: PAR_EN and PAR_TYP are sampled at the IDLE->START_CHK transition and held for the frame. Mid-frame changes have no effect.
- Reset mid-frame: the frame is abandoned and all outputs return to reset values immediately.
- Line held low (break): a stop majority of 0 gives STP_ERR. The receiver then re-arms in IDLE and treats the continuing low as a new start.

Decomposition:
- Package uart_rx_pkg holds:
  - state encodings IDLE, START_CHK, DATA, PARITY, STOP_CHK, DONE (3-bit);
  - sampling offset constants derived from PRESCALE;
  - STOP/START level constants shared with uart_tx.
- Sub-module uart_rx_sampler holds the edge counter, the 3-sample majority vote and a sample_done strobe. The FSM, shift register and parity check stay in uart_rx.

Test Plan:
- PRESCALE=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 (parity bit 0, stop 1) -> exactly one DATA_VALID pulse, P_DATA=0xA5, PAR_ERR=STP_ERR=0, Busy high about 88 clk.
- Same frame with parity bit forced to 1 -> PAR_ERR pulse, no DATA_VALID, P_DATA keeps previous value.
- PAR_EN=0, frame 0x3C with stop bit 0 -> STP_ERR pulse, no DATA_VALID.
- RX_IN low for 2 clk then high -> returns to IDLE, no strobes, Busy drops within PRESCALE+3 clk.
- Two back-to-back frames 0x01 then 0xFE, no idle gap -> two DATA_VALID pulses with P_DATA 0x01 then 0xFE.
- rst asserted mid-DATA of frame 0x55, then a clean frame 0x66 -> outputs zero during reset, then a single DATA_VALID with P_DATA=0x66.
